// File: rtl/warp_xwb_pkg.sv
// Shared definitions for the scalar writeback arbiter: datapath widths,
// the registered write-port record and a pointer-width helper.
package warp_xwb_pkg;

  localparam int unsigned XLEN       = 64;
  localparam int unsigned XRF_AWIDTH = 5;

  typedef logic [XRF_AWIDTH-1:0] xreg_t;
  typedef logic [XLEN-1:0]       xdata_t;

  // One register-file write port as driven from the output registers.
  typedef struct packed {
    logic   wen;
    xreg_t  addr;
    xdata_t data;
  } wr_port_t;

  // Width of a round-robin pointer over n sources (at least one bit).
  function automatic int unsigned ptr_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/warp_xwb_rr_pick2.sv
// Combinational two-slot round-robin picker. Scans sources starting at
// rr_ptr_i; slot0 is the first valid source, slot1 the next valid source
// whose destination does not collide with slot0 (x0 never collides).
module warp_rr_pick2
  import warp_xwb_pkg::*;
#(
  parameter int unsigned NSRC = 4,
  parameter int unsigned PtrW = ptr_width(NSRC)
) (
  input  logic [NSRC-1:0]            valid_i,
  input  logic [NSRC*XRF_AWIDTH-1:0] rd_i,
  input  logic [PtrW-1:0]            rr_ptr_i,
  output logic [NSRC-1:0]            grant0_o,
  output logic [NSRC-1:0]            grant1_o,
  output logic                       found0_o,
  output logic                       found1_o,
  output logic [PtrW-1:0]            idx0_o,
  output logic [PtrW-1:0]            idx1_o
);

  xreg_t rd0;
  xreg_t cand;
  int    idx;

  // Rotating scan: first valid wins slot0, first non-conflicting valid after it wins slot1.
  always_comb begin
    grant0_o = '0;
    grant1_o = '0;
    found0_o = 1'b0;
    found1_o = 1'b0;
    idx0_o   = '0;
    idx1_o   = '0;
    rd0      = '0;
    cand     = '0;
    idx      = 0;
    for (int k = 0; k < int'(NSRC); k++) begin
      idx  = (int'(rr_ptr_i) + k) % int'(NSRC);
      cand = rd_i[idx*XRF_AWIDTH +: XRF_AWIDTH];
      if (valid_i[idx]) begin
        if (!found0_o) begin
          found0_o      = 1'b1;
          grant0_o[idx] = 1'b1;
          idx0_o        = PtrW'(idx);
          rd0           = cand;
        end else if (!found1_o && ((cand != rd0) || (cand == '0))) begin
          // Same nonzero rd as slot0 is skipped so both ports never target one register.
          found1_o      = 1'b1;
          grant1_o[idx] = 1'b1;
          idx1_o        = PtrW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/warp_xwb.sv
// Scalar writeback arbiter: accepts up to two producer results per cycle in
// round-robin order and drives the register file's two write ports from
// registers one cycle after the grant.
module warp_xwb
  import warp_xwb_pkg::*;
#(
  parameter int unsigned NSRC = 4
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NSRC-1:0]            i_src_valid,
  output logic [NSRC-1:0]            o_src_ready,
  input  logic [NSRC*XRF_AWIDTH-1:0] i_src_rd,
  input  logic [NSRC*XLEN-1:0]       i_src_data,
  output logic [XRF_AWIDTH-1:0]      o_rd1_addr,
  output logic [XLEN-1:0]            o_rd1_wdata,
  output logic                       o_rd1_wen,
  output logic [XRF_AWIDTH-1:0]      o_rd2_addr,
  output logic [XLEN-1:0]            o_rd2_wdata,
  output logic                       o_rd2_wen,
  output logic                       o_busy
);

  localparam int unsigned PtrW = ptr_width(NSRC);

  logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NSRC-1:0] grant0, grant1;
  logic            found0, found1;
  logic [PtrW-1:0] idx0, idx1;
  xreg_t           slot0_rd, slot1_rd;
  xdata_t          slot0_data, slot1_data;
  wr_port_t        wr1_q, wr1_d, wr2_q, wr2_d;

  function automatic logic [PtrW-1:0] ptr_next(logic [PtrW-1:0] p);
    return (int'(p) == int'(NSRC) - 1) ? '0 : p + PtrW'(1);
  endfunction

  warp_rr_pick2 #(
    .NSRC (NSRC),
    .PtrW (PtrW)
  ) u_pick (
    .valid_i  (i_src_valid),
    .rd_i     (i_src_rd),
    .rr_ptr_i (rr_ptr_q),
    .grant0_o (grant0),
    .grant1_o (grant1),
    .found0_o (found0),
    .found1_o (found1),
    .idx0_o   (idx0),
    .idx1_o   (idx1)
  );

  // Handshake outputs; nothing is accepted while reset is asserted.
  always_comb begin
    o_src_ready = (grant0 | grant1) & {NSRC{i_rst_n}};
    o_busy      = i_rst_n & (|(i_src_valid & ~o_src_ready));
  end

  // Select the granted producers' rd/data for the two slots.
  always_comb begin
    slot0_rd   = i_src_rd[idx0*XRF_AWIDTH +: XRF_AWIDTH];
    slot1_rd   = i_src_rd[idx1*XRF_AWIDTH +: XRF_AWIDTH];
    slot0_data = i_src_data[idx0*XLEN +: XLEN];
    slot1_data = i_src_data[idx1*XLEN +: XLEN];
  end

  // Next write-port contents; an unused slot only drops wen, addr/data hold.
  always_comb begin
    wr1_d     = wr1_q;
    wr2_d     = wr2_q;
    wr1_d.wen = 1'b0;
    wr2_d.wen = 1'b0;
    if (found0) begin
      wr1_d.wen  = (slot0_rd != '0);
      wr1_d.addr = slot0_rd;
      wr1_d.data = slot0_data;
    end
    if (found1) begin
      wr2_d.wen  = (slot1_rd != '0);
      wr2_d.addr = slot1_rd;
      wr2_d.data = slot1_data;
    end
  end

  // Pointer moves just past the last source granted this cycle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found1) begin
      rr_ptr_d = ptr_next(idx1);
    end else if (found0) begin
      rr_ptr_d = ptr_next(idx0);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rr_ptr_q <= '0;
      wr1_q    <= '0;
      wr2_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      wr1_q    <= wr1_d;
      wr2_q    <= wr2_d;
    end
  end

  // Drive the register-file ports straight from the registers.
  always_comb begin
    o_rd1_addr  = wr1_q.addr;
    o_rd1_wdata = wr1_q.data;
    o_rd1_wen   = wr1_q.wen;
    o_rd2_addr  = wr2_q.addr;
    o_rd2_wdata = wr2_q.data;
    o_rd2_wen   = wr2_q.wen;
  end

endmodule

// File: tb/tb_warp_xwb.sv
// Directed bench for warp_xwb: stimulus pushes expected register-file writes
// into a queue; a negedge monitor pops and compares whenever a port writes.
module tb_warp_xwb;

  localparam int NSRC = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NSRC-1:0]   valid;
  logic [NSRC-1:0]   ready;
  logic [NSRC*5-1:0] rd;
  logic [NSRC*64-1:0] data;
  logic [4:0]        rd1_addr, rd2_addr;
  logic [63:0]       rd1_wdata, rd2_wdata;
  logic              rd1_wen, rd2_wen, busy;

  warp_xwb #(
    .NSRC (NSRC)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_src_valid (valid),
    .o_src_ready (ready),
    .i_src_rd    (rd),
    .i_src_data  (data),
    .o_rd1_addr  (rd1_addr),
    .o_rd1_wdata (rd1_wdata),
    .o_rd1_wen   (rd1_wen),
    .o_rd2_addr  (rd2_addr),
    .o_rd2_wdata (rd2_wdata),
    .o_rd2_wen   (rd2_wen),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w1;
    logic [4:0]  a1;
    logic [63:0] d1;
    logic        c1;
    logic        w2;
    logic [4:0]  a2;
    logic [63:0] d2;
    logic        c2;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   gcnt[NSRC];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_src(input int i, input logic [4:0] r, input logic [63:0] d);
    rd[i*5 +: 5]    = r;
    data[i*64 +: 64] = d;
  endtask

  task automatic push(input logic w1, input logic [4:0] a1, input logic [63:0] d1,
                      input logic c1, input logic w2, input logic [4:0] a2,
                      input logic [63:0] d2, input logic c2);
    exp_t e;
    e.w1 = w1; e.a1 = a1; e.d1 = d1; e.c1 = c1;
    e.w2 = w2; e.a2 = a2; e.d2 = d2; e.c2 = c2;
    q.push_back(e);
  endtask

  // Move to the drive point of the next cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every cycle in which a write port is enabled.
  always @(negedge clk) begin
    if (rd1_wen || rd2_wen) begin
      if (rd1_wen && rd2_wen) begin
        check("ports_same_addr", {63'd0, rd1_addr == rd2_addr}, 64'd0);
      end
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: got wen1=%0b addr1=%0d wen2=%0b addr2=%0d expected none",
                 rd1_wen, rd1_addr, rd2_wen, rd2_addr);
      end else begin
        mon_e = q.pop_front();
        check("rd1_wen", {63'd0, rd1_wen}, {63'd0, mon_e.w1});
        if (mon_e.c1) begin
          check("rd1_addr", {59'd0, rd1_addr}, {59'd0, mon_e.a1});
          check("rd1_wdata", rd1_wdata, mon_e.d1);
        end
        check("rd2_wen", {63'd0, rd2_wen}, {63'd0, mon_e.w2});
        if (mon_e.c2) begin
          check("rd2_addr", {59'd0, rd2_addr}, {59'd0, mon_e.a2});
          check("rd2_wdata", rd2_wdata, mon_e.d2);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NSRC; i++) gcnt[i] = 0;
    // Reset with every source valid.
    rst_n = 1'b0;
    valid = '1;
    for (int i = 0; i < NSRC; i++) set_src(i, 5'(i + 11), 64'(i + 64'h50));
    #2;
    check("reset_ready", 64'(ready), 64'h0);
    check("reset_busy", 64'(busy), 64'h0);
    next_cycle();
    check("reset_wen1", 64'(rd1_wen), 64'h0);
    check("reset_wen2", 64'(rd2_wen), 64'h0);
    check("reset_addr1", 64'(rd1_addr), 64'h0);
    check("reset_addr2", 64'(rd2_addr), 64'h0);
    rst_n = 1'b1;
    valid = '0;
    next_cycle();

    // Single source 2.
    next_cycle();
    valid = 4'b0100;
    set_src(2, 5'd7, 64'hDEAD);
    #1;
    check("single_ready", 64'(ready), 64'h4);
    check("single_busy", 64'(busy), 64'h0);
    push(1'b1, 5'd7, 64'hDEAD, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);

    // rr_ptr now 3: source 3 alone brings it back to 0.
    next_cycle();
    valid = 4'b1000;
    set_src(3, 5'd10, 64'h1010);
    #1;
    check("ptr3_ready", 64'(ready), 64'h8);
    push(1'b1, 5'd10, 64'h1010, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);

    // Two grants per cycle from rr_ptr=0.
    next_cycle();
    valid = 4'b1111;
    for (int i = 0; i < NSRC; i++) set_src(i, 5'(i + 1), 64'(i + 64'h100));
    #1;
    check("pair_ready_a", 64'(ready), 64'h3);
    check("pair_busy_a", 64'(busy), 64'h1);
    push(1'b1, 5'd1, 64'h100, 1'b1, 1'b1, 5'd2, 64'h101, 1'b1);
    next_cycle();
    valid = 4'b1100;
    #1;
    check("pair_ready_b", 64'(ready), 64'hC);
    check("pair_busy_b", 64'(busy), 64'h0);
    push(1'b1, 5'd3, 64'h102, 1'b1, 1'b1, 5'd4, 64'h103, 1'b1);

    // Same-rd conflict: src1 skipped in favour of src2.
    next_cycle();
    valid = 4'b0111;
    set_src(0, 5'd5, 64'h200);
    set_src(1, 5'd5, 64'h201);
    set_src(2, 5'd6, 64'h202);
    #1;
    check("conflict_ready", 64'(ready), 64'h5);
    check("conflict_busy", 64'(busy), 64'h1);
    push(1'b1, 5'd5, 64'h200, 1'b1, 1'b1, 5'd6, 64'h202, 1'b1);
    next_cycle();
    valid = 4'b0010;
    #1;
    check("conflict_late_ready", 64'(ready), 64'h2);
    push(1'b1, 5'd5, 64'h201, 1'b1, 1'b0, 5'd0, 64'd0, 1'b0);

    // x0 result consumes slot0 without a write; rr_ptr=2, scan 2,3,0,1.
    next_cycle();
    valid = 4'b0011;
    set_src(0, 5'd0, 64'h300);
    set_src(1, 5'd9, 64'h301);
    #1;
    check("x0_ready", 64'(ready), 64'h3);
    push(1'b0, 5'd0, 64'h300, 1'b1, 1'b1, 5'd9, 64'h301, 1'b1);

    // Fairness: all valid for 8 cycles starting from rr_ptr=2.
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      if (c == 0) begin
        valid = 4'b1111;
        for (int i = 0; i < NSRC; i++) set_src(i, 5'(i + 1), 64'(i + 64'hF00));
      end
      #1;
      for (int i = 0; i < NSRC; i++) gcnt[i] += (ready[i] && valid[i]) ? 1 : 0;
      if (c % 2 == 0) begin
        check("fair_ready_even", 64'(ready), 64'hC);
        push(1'b1, 5'd3, 64'hF02, 1'b1, 1'b1, 5'd4, 64'hF03, 1'b1);
      end else begin
        check("fair_ready_odd", 64'(ready), 64'h3);
        push(1'b1, 5'd1, 64'hF00, 1'b1, 1'b1, 5'd2, 64'hF01, 1'b1);
      end
    end
    for (int i = 0; i < NSRC; i++) check("fair_grant_count", 64'(gcnt[i]), 64'd4);

    // Reset mid-stream with sources still valid; rr_ptr was 2 before it.
    next_cycle();
    rst_n = 1'b0;
    #1;
    check("midreset_ready", 64'(ready), 64'h0);
    check("midreset_busy", 64'(busy), 64'h0);
    next_cycle();
    check("midreset_wen1", 64'(rd1_wen), 64'h0);
    check("midreset_wen2", 64'(rd2_wen), 64'h0);
    rst_n = 1'b1;
    #1;
    check("postreset_ready", 64'(ready), 64'h3);
    push(1'b1, 5'd1, 64'hF00, 1'b1, 1'b1, 5'd2, 64'hF01, 1'b1);

    next_cycle();
    valid = '0;
    next_cycle();
    next_cycle();
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
